// File: rtl/alu_issue.sv
// Instruction-issue controller for the 8-bit ALU: owns a 4-entry register file,
// sequences one instruction at a time through IDLE -> (EXEC) -> RESP.
module alu_issue #(
  parameter int NREGS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs,
  input  logic [1:0]       in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [1:0]       out_rd,
  output logic             out_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_READ = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [1:0] SEL_OR = 2'b11;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] regs [NREGS];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_sel  <= '0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_rd   <= '0;
      out_err  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q <= in_op;
            rd_q <= in_rd;
            case (in_op)
              OP_LDI: begin
                regs[in_rd] <= in_imm;
                out_data    <= in_imm;
                out_zero    <= (in_imm == '0);
                out_rd      <= in_rd;
                out_err     <= 1'b0;
                state       <= ST_RESP;
              end
              OP_ILL: begin
                out_data <= '0;
                out_zero <= 1'b0;
                out_rd   <= in_rd;
                out_err  <= 1'b1;
                state    <= ST_RESP;
              end
              OP_MOV, OP_READ: begin
                // Pass-through is an OR with zero so the ALU stays the only arithmetic path.
                alu_x   <= regs[in_rs];
                alu_y   <= '0;
                alu_sel <= SEL_OR;
                state   <= ST_EXEC;
              end
              default: begin
                alu_x   <= regs[in_rs];
                alu_y   <= regs[in_rt];
                alu_sel <= in_op[1:0];
                state   <= ST_EXEC;
              end
            endcase
          end
        end
        ST_EXEC: begin
          out_data <= alu_result;
          out_zero <= alu_zero;
          out_rd   <= rd_q;
          out_err  <= 1'b0;
          if (op_q != OP_READ) regs[rd_q] <= alu_result;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
